// File: rtl/adj_fm_wm_row_buffer.sv
// adj_fm_wm_row_buffer: row-organised accumulation buffer holding the
// ADJ*FM*WM matrix between the combination stage and the argmax stage.
//
// A frame starts with `start`: the buffer clears one row per cycle, then
// accepts accumulate beats (row[c] += acc_data[c]) until a beat carrying
// `acc_last`. It then holds `done_comb` and serves combinational row reads.
//
// Ports:
//   clk                 in   clock
//   reset               in   synchronous active-high reset
//   start               in   begin a new frame (clear, then accumulate)
//   acc_valid           in   accumulate beat valid
//   acc_ready           out  buffer is accepting beats (ACCUM only)
//   acc_row             in   target row of the beat
//   acc_data            in   vector added to the target row
//   acc_last            in   final beat of the frame
//   done_comb           out  matrix complete and readable
//   addr_err            out  sticky: a beat targeted a row >= DOT_PROD_ROWS
//   read_row_ADJ_FM_WM  in   row read address from argmax
//   ADJ_FM_WM_Row       out  row read data, zero for out-of-range rows
//
// Optional feature: define ADJ_FM_WM_SATURATE_EN to clamp each column sum
// to all-ones on carry-out; otherwise sums wrap modulo 2^ADJ_DOT_PROD_WIDTH.

module adj_fm_wm_row_buffer #(
    parameter int DOT_PROD_ROWS      = 6,
    parameter int DOT_PROD_COLS      = 3,
    parameter int ADJ_DOT_PROD_WIDTH = 16,
    parameter int FEATURE_WIDTH      = $clog2(DOT_PROD_ROWS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         acc_valid,
    output logic                         acc_ready,
    input  logic [FEATURE_WIDTH-1:0]     acc_row,
    input  logic [0:DOT_PROD_COLS-1][ADJ_DOT_PROD_WIDTH-1:0] acc_data,
    input  logic                         acc_last,
    output logic                         done_comb,
    output logic                         addr_err,
    input  logic [FEATURE_WIDTH-1:0]     read_row_ADJ_FM_WM,
    output logic [0:DOT_PROD_COLS-1][ADJ_DOT_PROD_WIDTH-1:0] ADJ_FM_WM_Row
);

    localparam logic [FEATURE_WIDTH:0] LP_ROWS =
        (FEATURE_WIDTH+1)'(DOT_PROD_ROWS);
    localparam logic [FEATURE_WIDTH-1:0] LP_LAST =
        FEATURE_WIDTH'(DOT_PROD_ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t                          r_state;
    logic [FEATURE_WIDTH-1:0]        r_cnt;
    logic                            r_acc_ready;
    logic                            r_done;
    logic                            r_addr_err;
    logic [ADJ_DOT_PROD_WIDTH-1:0]   r_mem [0:DOT_PROD_ROWS-1][0:DOT_PROD_COLS-1];

    logic                            w_row_ok;
    logic [FEATURE_WIDTH-1:0]        w_row_sel;
    logic                            w_rd_ok;
    logic                            w_start;
    logic [ADJ_DOT_PROD_WIDTH-1:0]   w_next [0:DOT_PROD_COLS-1];
`ifdef ADJ_FM_WM_SATURATE_EN
    logic [ADJ_DOT_PROD_WIDTH:0]     w_wide [0:DOT_PROD_COLS-1];
`endif

    // start is ignored while the clear sweep is running
    assign w_start   = start && (r_state != S_CLEAR);
    assign w_row_ok  = {1'b0, acc_row} < LP_ROWS;
    assign w_row_sel = w_row_ok ? acc_row : '0;
    assign w_rd_ok   = {1'b0, read_row_ADJ_FM_WM} < LP_ROWS;

    // Column adders read the registered row, so back-to-back beats to the
    // same row chain through the value written on the previous edge.
    always_comb begin
        for (int c = 0; c < DOT_PROD_COLS; c++) begin
`ifdef ADJ_FM_WM_SATURATE_EN
            w_wide[c] = {1'b0, r_mem[w_row_sel][c]} + {1'b0, acc_data[c]};
            w_next[c] = w_wide[c][ADJ_DOT_PROD_WIDTH]
                      ? '1 : w_wide[c][ADJ_DOT_PROD_WIDTH-1:0];
`else
            w_next[c] = r_mem[w_row_sel][c] + acc_data[c];
`endif
        end
    end

    always_comb begin
        ADJ_FM_WM_Row = '0;
        if (w_rd_ok) begin
            for (int c = 0; c < DOT_PROD_COLS; c++) begin
                ADJ_FM_WM_Row[c] = r_mem[read_row_ADJ_FM_WM][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc_ready <= 1'b0;
            r_done      <= 1'b0;
            r_addr_err  <= 1'b0;
            for (int r = 0; r < DOT_PROD_ROWS; r++) begin
                for (int c = 0; c < DOT_PROD_COLS; c++) begin
                    r_mem[r][c] <= '0;
                end
            end
        end else if (w_start) begin
            // New frame, also aborts an ACCUM frame in progress
            r_state     <= S_CLEAR;
            r_cnt       <= '0;
            r_acc_ready <= 1'b0;
            r_done      <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_acc_ready <= 1'b0;
                    r_done      <= 1'b0;
                end
                S_CLEAR: begin
                    for (int c = 0; c < DOT_PROD_COLS; c++) begin
                        r_mem[r_cnt][c] <= '0;
                    end
                    if (r_cnt == LP_LAST) begin
                        r_state     <= S_ACCUM;
                        r_acc_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (acc_valid) begin
                        // Out-of-range beats are consumed without a write
                        if (w_row_ok) begin
                            for (int c = 0; c < DOT_PROD_COLS; c++) begin
                                r_mem[w_row_sel][c] <= w_next[c];
                            end
                        end else begin
                            r_addr_err <= 1'b1;
                        end
                        if (acc_last) begin
                            r_state     <= S_DONE;
                            r_acc_ready <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign acc_ready = r_acc_ready;
    assign done_comb = r_done;
    assign addr_err  = r_addr_err;

endmodule

// File: doc/adj_fm_wm_row_buffer.md
# adj_fm_wm_row_buffer

Row-organised accumulation buffer holding the ADJ·FM·WM result matrix between the combination stage and the argmax stage. The combination datapath pushes row-vector partial sums that are accumulated per row. The buffer then asserts `done_comb` and serves single-cycle row reads on `read_row_ADJ_FM_WM` / `ADJ_FM_WM_Row`, which is the responder end of the argmax read interface.

## Interface
- `DOT_PROD_ROWS`, 6, number of stored rows (nodes)
- `DOT_PROD_COLS`, 3, columns per row (classes)
- `ADJ_DOT_PROD_WIDTH`, 16, unsigned element width
- `FEATURE_WIDTH`, `$clog2(DOT_PROD_ROWS)`, row address width

Ports (one clock, `clk`; reset `reset` is synchronous, active-high):
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `start`  in  1  begin new frame (clear, then accumulate)
- `acc_valid`  in  1  accumulate beat valid
- `acc_ready`  out  1  buffer accepting beats
- `acc_row`  in  `FEATURE_WIDTH`  target row of beat
- `acc_data`  in  `ADJ_DOT_PROD_WIDTH` x `[0:DOT_PROD_COLS-1]`  vector added to target row
- `acc_last`  in  1  final beat of frame
- `done_comb`  out  1  matrix complete, readable
- `addr_err`  out  1  sticky, a beat targeted row >= `DOT_PROD_ROWS`
- `read_row_ADJ_FM_WM`  in  `FEATURE_WIDTH`  row read address from argmax
- `ADJ_FM_WM_Row`  out  `ADJ_DOT_PROD_WIDTH` x `[0:DOT_PROD_COLS-1]`  row read data

## Operation
- Storage: `DOT_PROD_ROWS` x `DOT_PROD_COLS` registers.
- FSM states: IDLE, CLEAR, ACCUM, DONE.
  - IDLE: `start` -> CLEAR.
  - CLEAR: a row counter zeroes row 0..`DOT_PROD_ROWS`-1, one row per cycle. After the last row it moves to ACCUM. `start` is ignored while in CLEAR.
  - ACCUM: `acc_ready`=1. A beat is accepted when `acc_valid && acc_ready`. Each column updates as row[c] <= row[c] + `acc_data`[c]. An accepted beat with `acc_last` -> DONE. `start` -> CLEAR (abort the frame, discard sums).
  - DONE: `done_comb`=1 and held. `start` -> CLEAR; `done_comb` drops on the same edge.
- `acc_ready` is 0 in all states except ACCUM.
- Out-of-range `acc_row`:
  - The beat is consumed but no storage changes.
  - `addr_err` sets and stays set until `reset` or the next `start`.
  - If the beat carries `acc_last`, it still completes the frame.
- Arithmetic: unsigned, `ADJ_DOT_PROD_WIDTH` bits, wraps modulo 2^W unless the saturation macro is defined.
- Read port: combinational, `ADJ_FM_WM_Row` = row[`read_row_ADJ_FM_WM`] in every state. An out-of-range address returns all zeros. Reads outside DONE return partial or cleared data.
- Back-to-back beats to the same row need no stall. Each beat reads the registered value already updated by the previous edge.

## Timing
- Reset state: FSM in IDLE, all storage 0, `acc_ready`=0, `done_comb`=0, `addr_err`=0, `ADJ_FM_WM_Row` = 0. A reset mid-frame aborts the frame and reaches this state after one edge.
- `start` sampled at edge t in IDLE or DONE: CLEAR occupies cycles t+1..t+`DOT_PROD_ROWS`. ACCUM and `acc_ready`=1 begin at cycle t+`DOT_PROD_ROWS`+1.
- Accumulate latency: a beat accepted at edge t is visible on the read port in cycle t+1.
- The `acc_last` beat accepted at edge t gives `done_comb`=1 from cycle t+1. The last beat's sum is already included.
- Read latency: zero cycles; data is valid in the same cycle as the address, for the argmax block's registered capture.
- Throughput: one beat per cycle, with no bubbles in ACCUM.

## Configuration
- `ADJ_FM_WM_SATURATE_EN`
  - Defined: each column sum clamps to 2^`ADJ_DOT_PROD_WIDTH`-1 on carry-out. Later beats keep the clamped value; they can only add and so remain saturated.
  - Undefined: sums wrap modulo 2^`ADJ_DOT_PROD_WIDTH`.

## Test plan
- Reset, then `start`:
  - `acc_ready` rises exactly 7 cycles after the `start` edge (defaults).
  - All rows read 0.
- Beats {row 2: (1,2,3)}, {row 2: (10,20,30)}, {row 5: (7,0,9), last} back-to-back:
  - Row 2 reads (11,22,33) and row 5 reads (7,0,9).
  - `done_comb` rises the cycle after the last beat and is held.
- With `done_comb` high, sweep `read_row_ADJ_FM_WM` 0..5, then 6 and 7:
  - Rows 0..5 return the correct vectors in the same cycle.
  - Addresses 6 and 7 return (0,0,0).
- Beat to row 6 with data (5,5,5):
  - `addr_err` becomes 1.
  - All rows are unchanged.
  - `addr_err` clears on the next `start`.
- Row 0 gets 0xFFF0 then 0x0020 in column 0:
  - Without the macro, row 0 column 0 reads 0x0010.
  - With `ADJ_FM_WM_SATURATE_EN`, it reads 0xFFFF.
- Aborts:
  - `start` asserted in ACCUM mid-frame: rows clear and a new frame runs.
  - `reset` asserted mid-CLEAR: the next cycle is IDLE with all outputs at their reset values.
